// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard-based RAW/WAW interlock, writeback bypass
// into the operand mux, and a one-entry output register toward execute.
module operand_fetch #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 16,
    localparam int A = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [A-1:0]          in_rs1,
    input  logic [A-1:0]          in_rs2,
    input  logic                  in_uses_rs1,
    input  logic                  in_uses_rs2,
    input  logic [A-1:0]          in_rd,
    input  logic                  in_rd_we,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic [A-1:0]          rf_raddr1,
    output logic [A-1:0]          rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    input  logic                  wb_valid,
    input  logic [A-1:0]          wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [A-1:0]          out_rd,
    output logic                  out_rd_we,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [31:0]           stall_count
);

    logic                  run_q;
    logic [NUM_REGS-1:0]   sb_q, sb_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [A-1:0]          rd_q, rd_d;
    logic                  rd_we_q, rd_we_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [31:0]           stall_q, stall_d;

    logic wb_hit1, wb_hit2, wb_hit_rd;
    logic haz_rs1, haz_rs2, haz_waw;
    logic issue;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    assign wb_hit1   = wb_valid && (wb_rd == in_rs1);
    assign wb_hit2   = wb_valid && (wb_rd == in_rs2);
    assign wb_hit_rd = wb_valid && (wb_rd == in_rd);

    // A writeback landing this cycle resolves the hazard it would otherwise cause.
    assign haz_rs1 = in_uses_rs1 && (in_rs1 != '0) && sb_q[in_rs1] && !wb_hit1;
    assign haz_rs2 = in_uses_rs2 && (in_rs2 != '0) && sb_q[in_rs2] && !wb_hit2;
    assign haz_waw = in_rd_we && (in_rd != '0) && sb_q[in_rd] && !wb_hit_rd;

    // run_q holds in_ready low through reset and until the first edge after release.
    assign in_ready = run_q && !haz_rs1 && !haz_rs2 && !haz_waw
                      && (!valid_q || out_ready);
    assign issue    = in_valid && in_ready;

    always_comb begin
        sb_d = sb_q;
        if (wb_valid) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (issue && in_rd_we && (in_rd != '0)) begin
            sb_d[in_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        rd_we_d = rd_we_q;
        ctrl_d  = ctrl_q;
        if (issue) begin
            valid_d = 1'b1;
            op1_d   = (in_rs1 == '0) ? '0 : (wb_hit1 ? wb_data : rf_rdata1);
            op2_d   = (in_rs2 == '0) ? '0 : (wb_hit2 ? wb_data : rf_rdata2);
            rd_d    = in_rd;
            rd_we_d = in_rd_we;
            ctrl_d  = in_ctrl;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            sb_q    <= '0;
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            rd_we_q <= 1'b0;
            ctrl_q  <= '0;
            stall_q <= '0;
        end else begin
            run_q   <= 1'b1;
            sb_q    <= sb_d;
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            rd_we_q <= rd_we_d;
            ctrl_q  <= ctrl_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_op1     = op1_q;
    assign out_op2     = op2_q;
    assign out_rd      = rd_q;
    assign out_rd_we   = rd_we_q;
    assign out_ctrl    = ctrl_q;
    assign stall_count = stall_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, operand width.
REQ-003 SHALL have parameter CTRL_WIDTH, default 16, opaque decoded-control passthrough width.
REQ-004 SHALL have ports (A = clog2(NUM_REGS)):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle.
- in_rs1, in_rs2  in  A  source register numbers.
- in_uses_rs1, in_uses_rs2  in  1  source actually read.
- in_rd  in  A  destination register.
- in_rd_we  in  1  instruction writes rd.
- in_ctrl  in  CTRL_WIDTH  passthrough control.
- rf_raddr1, rf_raddr2  out  A  register-file read addresses.
- rf_rdata1, rf_rdata2  in  DATA_WIDTH  register-file combinational read data.
- wb_valid  in  1  writeback occurring this cycle.
- wb_rd  in  A  writeback destination.
- wb_data  in  DATA_WIDTH  writeback value.
- out_valid  out  1  operands valid to execute.
- out_ready  in  1  execute accepts.
- out_op1, out_op2  out  DATA_WIDTH  resolved operands.
- out_rd, out_rd_we, out_ctrl  out  A/1/CTRL_WIDTH  registered copies.
- stall_count  out  32  saturating stall-cycle counter.

Function
REQ-005 SHALL drive rf_raddr1 = in_rs1 and rf_raddr2 = in_rs2 combinationally.
REQ-006 SHALL keep a NUM_REGS-bit scoreboard; bit n set means register n has an issued, unretired write; bit 0 is never set.
REQ-007 Source hazard SHALL be: in_uses_rsX and in_rsX != 0 and scoreboard[in_rsX] and not (wb_valid and wb_rd == in_rsX).
REQ-008 WAW hazard SHALL be: in_rd_we and in_rd != 0 and scoreboard[in_rd] and not (wb_valid and wb_rd == in_rd).
REQ-009 in_ready SHALL be: no source hazard, no WAW hazard, and (not out_valid or out_ready); combinational.
REQ-010 Issue SHALL be in_valid and in_ready; on issue the output register loads at the next edge, giving 1-cycle latency.
REQ-011 Operand X SHALL be: 0 if in_rsX == 0; else wb_data if wb_valid and wb_rd == in_rsX; else rf_rdataX.
REQ-012 Operand selection SHALL ignore in_uses_rsX, so unused operands still carry the selected value.
REQ-013 On issue with in_rd_we and in_rd != 0, the scoreboard SHALL set bit in_rd.
REQ-014 wb_valid SHALL clear scoreboard[wb_rd]; when it coincides with a set of the same bit, the set SHALL win.
REQ-015 wb_valid to a non-busy register or to register 0 SHALL leave the scoreboard unchanged.
REQ-016 While out_valid and not out_ready, all out_* SHALL hold stable.
REQ-017 When out_valid and out_ready with no issue, out_valid SHALL drop to 0 at the next edge.
REQ-018 When out_valid and out_ready with an issue in the same cycle, the new instruction SHALL load without a bubble.
REQ-019 stall_count SHALL increment each cycle in which in_valid and not in_ready, and SHALL saturate at 0xFFFFFFFF.
REQ-020 in_ready SHALL not depend on in_valid.

Reset
REQ-021 rst_n low SHALL asynchronously clear out_valid, out_op1, out_op2, out_rd, out_rd_we, out_ctrl, the scoreboard and stall_count to 0.
REQ-022 While rst_n is low, in_ready SHALL be 0.
REQ-023 Deassertion SHALL take effect at the first clk rising edge after rst_n goes high.
REQ-024 Reset asserted mid-operation SHALL discard the held instruction and all scoreboard state.

Verification
REQ-025 Issue rs1=3, rs2=0, rf_rdata1=0x11, with scoreboard empty and out_ready=1 -> next cycle out_valid=1, out_op1=0x11, out_op2=0.
REQ-026 Issue rd=5 with rd_we, then next instruction uses rs1=5 -> in_ready=0 and stall_count increments until wb_valid, wb_rd=5, wb_data=0xAB; in that wb cycle it issues with out_op1=0xAB.
REQ-027 Hold out_ready=0 with out_valid=1 for 4 cycles -> out_* unchanged, in_ready=0, stall_count +4 while in_valid=1.
REQ-028 Issue with rd=7 in the same cycle as wb_valid, wb_rd=7 clears an older write -> scoreboard[7]=1 afterwards.
REQ-029 Assert rst_n low with out_valid=1 and scoreboard nonzero -> out_valid=0, scoreboard=0 and stall_count=0 immediately, without a clk edge.
